// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, RAM region decode and the command payload
// registered by initiators for the duration of a cycle.
package wb_pkg;

    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned WB_SEL_WIDTH  = 4;

    // Region decode field shared with the RAM interface slave
    localparam int unsigned DECODE_MSB   = 16;
    localparam int unsigned DECODE_LSB   = 13;
    localparam int unsigned DECODE_WIDTH = DECODE_MSB - DECODE_LSB + 1;

    localparam logic [DECODE_WIDTH-1:0] IRAM_REGION = 4'h0;
    localparam logic [DECODE_WIDTH-1:0] DRAM_REGION = 4'h1;
    localparam logic [31:0]             IRAM_MASK   = 32'h0000_1FFF;
    localparam logic [31:0]             DRAM_MASK   = 32'h0000_1FFF;

    typedef struct packed {
        logic                     we;
        logic [WB_SEL_WIDTH-1:0]  sel;
        logic [WB_DATA_WIDTH-1:0] wdata;
    } wb_cmd_t;

    function automatic logic [DECODE_WIDTH-1:0] decode_region(input logic [31:0] addr);
        return addr[DECODE_MSB:DECODE_LSB];
    endfunction

endpackage

// File: rtl/wb_master_bridge_if.sv
// Wishbone classic bus between one initiator and the interconnect.
interface wb_master_bridge_if
    import wb_pkg::*;
#(
    parameter int unsigned WB_ADDR_WIDTH = 32
);
    logic                     wb_cyc_o;
    logic                     wb_stb_o;
    logic                     wb_we_o;
    logic [WB_SEL_WIDTH-1:0]  wb_sel_o;
    logic [WB_ADDR_WIDTH-1:0] wb_addr_o;
    logic [WB_DATA_WIDTH-1:0] wb_wdata_o;
    logic [WB_DATA_WIDTH-1:0] wb_rdata_i;
    logic                     wb_ack_i;
    logic                     wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_wdata_o,
        input  wb_rdata_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_wdata_o,
        output wb_rdata_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_master_bridge.sv
// Core req/gnt to Wishbone classic initiator: one bus cycle per granted request,
// one rvalid pulse per cycle, with an optional timeout for unacknowledged cycles.
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     req_i,
    output logic                     gnt_o,
    input  logic [WB_ADDR_WIDTH-1:0] addr_i,
    input  logic                     we_i,
    input  logic [WB_SEL_WIDTH-1:0]  be_i,
    input  logic [WB_DATA_WIDTH-1:0] wdata_i,
    output logic                     rvalid_o,
    output logic [WB_DATA_WIDTH-1:0] rdata_o,
    output logic                     err_o,
    wb_master_bridge_if.master       wb
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_e;

    state_e                   state_q;
    logic                     cyc_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [WB_ADDR_WIDTH-1:0] addr_q;
    wb_cmd_t                  cmd_q;
    logic                     timeout_c;
    logic                     done_c;

    assign gnt_o     = req_i & en_i & (state_q == S_IDLE);
    assign timeout_c = TIMEOUT_EN && (cnt_q == CNT_LAST);
    assign done_c    = wb.wb_err_i | wb.wb_ack_i | timeout_c;

    // Transfer sequencer; all bus and response outputs come straight from flops
    always_ff @(posedge wb_clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cyc_q    <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            cmd_q    <= '0;
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_o) begin
                        addr_q  <= addr_i;
                        cmd_q   <= '{we: we_i, sel: be_i, wdata: wdata_i};
                        cyc_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_BUS;
                    end
                end
                S_BUS: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (done_c) begin
                        cyc_q    <= 1'b0;
                        rvalid_o <= 1'b1;
                        state_q  <= S_RESP;
                        // err beats ack; neither means the timeout fired
                        err_o    <= wb.wb_err_i | ~wb.wb_ack_i;
                        if (wb.wb_ack_i && !wb.wb_err_i && !cmd_q.we) begin
                            rdata_o <= wb.wb_rdata_i;
                        end
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wb.wb_cyc_o   = cyc_q;
    assign wb.wb_stb_o   = cyc_q;
    assign wb.wb_we_o    = cmd_q.we;
    assign wb.wb_sel_o   = cmd_q.sel;
    assign wb.wb_addr_o  = addr_q;
    assign wb.wb_wdata_o = cmd_q.wdata;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: directed vector table, randomized
// transfers against a timeline model, and hand sequences for reset/enable corners.
module tb_wb_master_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned TO = 4;

    logic        wb_clk_i = 1'b0;
    logic        rst_ni   = 1'b0;
    logic        en_i     = 1'b0;
    logic        req_i    = 1'b0;
    logic        gnt_o;
    logic [31:0] addr_i   = '0;
    logic        we_i     = 1'b0;
    logic [3:0]  be_i     = '0;
    logic [31:0] wdata_i  = '0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_master_bridge_if #(.WB_ADDR_WIDTH(AW)) bus ();

    wb_master_bridge #(
        .WB_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .rst_ni  (rst_ni),
        .en_i    (en_i),
        .req_i   (req_i),
        .gnt_o   (gnt_o),
        .addr_i  (addr_i),
        .we_i    (we_i),
        .be_i    (be_i),
        .wdata_i (wdata_i),
        .rvalid_o(rvalid_o),
        .rdata_o (rdata_o),
        .err_o   (err_o),
        .wb      (bus)
    );

    // kind: bit0 = ack, bit1 = err, driven only in cycle ack_cyc (0 = slave never answers)
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int unsigned ack_cyc;
        logic [1:0]  kind;
        logic [31:0] sdata;
        int unsigned exp_resp;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } txn_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_rdata;
    txn_t        vec[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge wb_clk_i);
    endtask

    task automatic idle_inputs();
        req_i          = 1'b0;
        en_i           = 1'b1;
        bus.wb_ack_i   = 1'b0;
        bus.wb_err_i   = 1'b0;
        bus.wb_rdata_i = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cyc"},   32'(bus.wb_cyc_o), 32'd0);
        chk({tag, "_stb"},   32'(bus.wb_stb_o), 32'd0);
        chk({tag, "_we"},    32'(bus.wb_we_o), 32'd0);
        chk({tag, "_sel"},   32'(bus.wb_sel_o), 32'd0);
        chk({tag, "_addr"},  bus.wb_addr_o, 32'd0);
        chk({tag, "_wdata"}, bus.wb_wdata_o, 32'd0);
        chk({tag, "_rvalid"}, 32'(rvalid_o), 32'd0);
        chk({tag, "_err"},   32'(err_o), 32'd0);
        chk({tag, "_rdata"}, rdata_o, 32'd0);
    endtask

    // One granted transfer; cycle 0 is the grant cycle, response expected in t.exp_resp
    task automatic run_txn(input string tag, input txn_t t);
        next_cycle();
        idle_inputs();
        req_i   = 1'b1;
        addr_i  = t.addr;
        we_i    = t.we;
        be_i    = t.be;
        wdata_i = t.wdata;
        sample();
        chk({tag, "_gnt0"}, 32'(gnt_o), 32'd1);
        chk({tag, "_cyc0"}, 32'(bus.wb_cyc_o), 32'd0);
        for (int c = 1; c <= int'(t.exp_resp); c++) begin
            next_cycle();
            req_i          = 1'($urandom_range(0, 1));
            en_i           = 1'($urandom_range(0, 1));
            addr_i         = $urandom;
            wdata_i        = $urandom;
            we_i           = 1'($urandom_range(0, 1));
            bus.wb_ack_i   = (c == int'(t.ack_cyc)) && t.kind[0];
            bus.wb_err_i   = (c == int'(t.ack_cyc)) && t.kind[1];
            bus.wb_rdata_i = (c == int'(t.ack_cyc)) ? t.sdata : $urandom;
            sample();
            chk({tag, "_gnt_busy"}, 32'(gnt_o), 32'd0);
            chk({tag, "_cyc"}, 32'(bus.wb_cyc_o), 32'(c < int'(t.exp_resp)));
            chk({tag, "_stb"}, 32'(bus.wb_stb_o), 32'(c < int'(t.exp_resp)));
            chk({tag, "_rvalid"}, 32'(rvalid_o), 32'(c == int'(t.exp_resp)));
            if (c < int'(t.exp_resp)) begin
                chk({tag, "_addr"},  bus.wb_addr_o, t.addr);
                chk({tag, "_we"},    32'(bus.wb_we_o), 32'(t.we));
                chk({tag, "_sel"},   32'(bus.wb_sel_o), 32'(t.be));
                chk({tag, "_wdata"}, bus.wb_wdata_o, t.wdata);
            end else begin
                chk({tag, "_err"},   32'(err_o), 32'(t.exp_err));
                chk({tag, "_rdata"}, rdata_o, t.exp_rdata);
            end
        end
        next_cycle();
        idle_inputs();
        sample();
        chk({tag, "_rvalid_after"}, 32'(rvalid_o), 32'd0);
        chk({tag, "_cyc_after"}, 32'(bus.wb_cyc_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;

        // we, addr, be, wdata, ack_cyc, kind, sdata, exp_resp, exp_err, exp_rdata
        vec[0] = '{1'b0, 32'h0000_2004, 4'hF, 32'h0,          3, 2'b01, 32'hDEAD_BEEF, 4, 1'b0, 32'hDEAD_BEEF};
        vec[1] = '{1'b1, 32'h0000_0010, 4'h3, 32'h1234_5678,  1, 2'b01, 32'h5555_AAAA, 2, 1'b0, 32'hDEAD_BEEF};
        vec[2] = '{1'b0, 32'h0000_0100, 4'hF, 32'h0,          0, 2'b01, 32'h1111_2222, 5, 1'b1, 32'hDEAD_BEEF};
        vec[3] = '{1'b0, 32'h0000_3000, 4'hF, 32'h0,          2, 2'b11, 32'hCAFE_F00D, 3, 1'b1, 32'hDEAD_BEEF};
        vec[4] = '{1'b1, 32'h0000_4008, 4'hC, 32'hA5A5_5A5A,  3, 2'b10, 32'h7777_7777, 4, 1'b1, 32'hDEAD_BEEF};
        vec[5] = '{1'b0, 32'h0001_E000, 4'h1, 32'h0,          4, 2'b01, 32'h0BAD_F00D, 5, 1'b0, 32'h0BAD_F00D};

        // Reset state
        idle_inputs();
        rst_ni = 1'b0;
        next_cycle();
        next_cycle();
        sample();
        chk_reset_outputs("reset");
        chk("reset_gnt", 32'(gnt_o), 32'd0);
        next_cycle();
        rst_ni = 1'b1;

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("vec%0d", i), vec[i]);
            model_rdata = vec[i].exp_rdata;
        end

        // Randomized transfers against the timeline model
        for (int i = 0; i < 40; i++) begin
            t.we      = 1'($urandom_range(0, 1));
            t.addr    = $urandom;
            t.be      = 4'($urandom);
            t.wdata   = $urandom;
            t.ack_cyc = $urandom_range(0, 6);
            t.kind    = 2'($urandom_range(1, 3));
            t.sdata   = $urandom;
            if (t.ack_cyc != 0 && t.ack_cyc <= TO) begin
                t.exp_resp  = t.ack_cyc + 1;
                t.exp_err   = (t.kind != 2'b01);
                t.exp_rdata = (t.kind == 2'b01 && !t.we) ? t.sdata : model_rdata;
            end else begin
                t.exp_resp  = TO + 1;
                t.exp_err   = 1'b1;
                t.exp_rdata = model_rdata;
            end
            run_txn($sformatf("rnd%0d", i), t);
            model_rdata = t.exp_rdata;
        end

        // Stray ack/err while idle produces no response
        next_cycle();
        bus.wb_ack_i = 1'b1;
        bus.wb_err_i = 1'b1;
        sample();
        chk("stray_cyc", 32'(bus.wb_cyc_o), 32'd0);
        next_cycle();
        idle_inputs();
        sample();
        chk("stray_rvalid", 32'(rvalid_o), 32'd0);
        chk("stray_rdata", rdata_o, model_rdata);

        // Back-to-back writes against an always-acking slave: grants every 3 cycles
        next_cycle();
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = 32'h0000_0040;
        be_i    = 4'hF;
        wdata_i = 32'h0000_00AA;
        bus.wb_ack_i = 1'b1;
        sample();
        chk("b2b_gnt_c0", 32'(gnt_o), 32'd1);
        chk("b2b_rvalid_c0", 32'(rvalid_o), 32'd0);
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            sample();
            chk($sformatf("b2b_gnt_c%0d", c), 32'(gnt_o), 32'(c % 3 == 0));
            chk($sformatf("b2b_rvalid_c%0d", c), 32'(rvalid_o), 32'(c % 3 == 2));
        end
        next_cycle();
        req_i = 1'b0;
        sample();
        chk("b2b_cyc_c7", 32'(bus.wb_cyc_o), 32'd1);
        next_cycle();
        idle_inputs();
        sample();
        chk("b2b_rvalid_c8", 32'(rvalid_o), 32'd1);
        chk("b2b_err_c8", 32'(err_o), 32'd0);
        next_cycle();
        sample();
        chk("b2b_rvalid_c9", 32'(rvalid_o), 32'd0);

        // Enable low blocks grants
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            req_i = 1'b1;
            en_i  = 1'b0;
            sample();
            chk($sformatf("en_gnt_c%0d", c), 32'(gnt_o), 32'd0);
            chk($sformatf("en_cyc_c%0d", c), 32'(bus.wb_cyc_o), 32'd0);
        end
        next_cycle();
        idle_inputs();

        // Reset asserted during a bus cycle drops it with no response
        next_cycle();
        req_i   = 1'b1;
        we_i    = 1'b0;
        addr_i  = 32'h0000_0044;
        be_i    = 4'h5;
        wdata_i = 32'h0F0F_0F0F;
        sample();
        chk("rst_gnt_c0", 32'(gnt_o), 32'd1);
        next_cycle();
        req_i = 1'b0;
        sample();
        chk("rst_cyc_c1", 32'(bus.wb_cyc_o), 32'd1);
        next_cycle();
        rst_ni = 1'b0;
        sample();
        chk("rst_cyc_c2", 32'(bus.wb_cyc_o), 32'd1);
        next_cycle();
        rst_ni = 1'b1;
        sample();
        chk_reset_outputs("rst_c3");
        chk("rst_gnt_c3", 32'(gnt_o), 32'd0);
        for (int c = 4; c < 7; c++) begin
            next_cycle();
            sample();
            chk($sformatf("rst_rvalid_c%0d", c), 32'(rvalid_o), 32'd0);
            chk($sformatf("rst_cyc_c%0d", c), 32'(bus.wb_cyc_o), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_master_bridge.md
# wb_master_bridge

Wishbone classic initiator that converts single load/store requests from a core-side req/gnt interface into one Wishbone read or write cycle. It returns one response per request on the core side. It is the master-side counterpart of the RAM interface slave and sits between the core LSU/fetch port and the Wishbone interconnect. At most one transfer is in flight, and a programmable timeout closes cycles that are never acknowledged.

## Interface
- WB_ADDR_WIDTH, 32, address width on both sides
- TIMEOUT_CYCLES, 16, BUS-state cycles before abort; 0 disables timeout
- wb_clk_i  in  1  clock; the block has a single clock
- rst_ni  in  1  reset, synchronous, active-low
- en_i  in  1  enable; low blocks new grants, in-flight transfer completes
- req_i  in  1  core request valid
- gnt_o  out  1  grant; request accepted this cycle
- addr_i  in  WB_ADDR_WIDTH  request address
- we_i  in  1  1 = write, 0 = read
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  one-cycle response pulse
- rdata_o  out  32  read data (valid with rvalid_o on reads)
- err_o  out  1  response is an error (valid with rvalid_o)
- wb_cyc_o, wb_stb_o  out  1 each  Wishbone cycle/strobe
- wb_we_o  out  1  Wishbone write enable
- wb_sel_o  out  4  Wishbone byte select
- wb_addr_o  out  WB_ADDR_WIDTH  Wishbone address
- wb_wdata_o  out  32  Wishbone write data
- wb_rdata_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge
- wb_err_i  in  1  Wishbone error

## Operation
- FSM states: IDLE, BUS, RESP.
- gnt_o = req_i & en_i & (state == IDLE). This is combinational and is the only path that accepts a request.
- IDLE: on gnt_o, register addr/we/be/wdata into the wb_* outputs and go to BUS.
- BUS: cyc = stb = 1, and the wb_* outputs are held stable. The timeout counter increments every cycle.
  - wb_err_i sampled high: go to RESP with err = 1. err takes priority over a simultaneous ack.
  - Else wb_ack_i high: go to RESP with err = 0. On reads, capture wb_rdata_i into rdata_o. On writes, rdata_o keeps its previous value.
  - Else counter == TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES != 0: go to RESP with err = 1.
- RESP: cyc = stb = 0, rvalid_o = 1 for exactly this cycle, err_o valid. The next state is always IDLE.
- wb_ack_i/wb_err_i in IDLE or RESP are ignored and produce no response.
- The counter clears on entry to BUS. Its width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
- en_i falling during BUS or RESP does not abort the transfer.

## Timing
- Reset values (synchronous, at the first edge with rst_ni low):
  - state = IDLE.
  - wb_cyc_o = wb_stb_o = wb_we_o = 0, wb_sel_o = 0, wb_addr_o = 0, wb_wdata_o = 0.
  - rvalid_o = 0, err_o = 0, rdata_o = 0.
  - gnt_o = 0 whenever state is not IDLE.
- Reset asserted mid-BUS drops cyc/stb at that edge. No response is issued for the dropped transfer.
- Transfer timeline, with grant in cycle 0 and ack first sampled high in cycle k ≥ 1:
  - cyc/stb high in cycles 1..k.
  - rvalid_o high in cycle k+1.
  - Next gnt possible in cycle k+2.
- Minimum interval between grants is 3 cycles, reached with a zero-wait slave (ack in cycle 1).
- Timeout with TIMEOUT_CYCLES = N: cyc/stb high in cycles 1..N, rvalid_o with err_o = 1 in cycle N+1.
- All wb_* outputs and core-side responses are registered. Only gnt_o is combinational.

## Structure
- A shared package, wb_pkg, holds:
  - the Wishbone data width (32) and select width (4);
  - IRAM/DRAM region masks and the address decode field [16:13], shared with the RAM interface slave.
- The FSM state enum stays local to the module.
- No sub-module. The timeout counter is inline.

## Test plan
- **Read, 2-cycle-wait slave:** req addr 0x0000_2004, we = 0. Slave acks in cycle 3 with 0xDEAD_BEEF. Expect gnt in cycle 0, cyc/stb in cycles 1–3, and rvalid in cycle 4 with rdata 0xDEAD_BEEF and err 0.
- **Write, zero-wait slave:** req addr 0x0000_0010, be 0x3, wdata 0x1234_5678. Expect wb_we = 1, sel 0x3 and data on the bus in cycle 1, ack in cycle 1, rvalid in cycle 2, rdata unchanged.
- **Timeout:** TIMEOUT_CYCLES = 4, no ack. Expect cyc high in cycles 1–4, rvalid with err 1 in cycle 5, cyc 0 in cycle 5.
- **Simultaneous ack and err:** ack and err both high in cycle 2. Expect err_o = 1 in cycle 3. Separately, a stray ack in IDLE produces no rvalid.
- **Back-to-back requests:** req_i held high for two requests. Expect a second gnt no earlier than cycle 3 after the first, and no gnt in cycles 1–2.
- **Reset and enable:**
  - rst_ni low in cycle 2 of BUS: cyc = 0 in cycle 3, no rvalid, all outputs at reset values.
  - en_i low with req_i high: gnt stays 0.
